multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 go_contr  input  1  start request; sampled only in IDLE.
REQ-005 ir  input  32  current instruction register contents.
REQ-006 zero  input  1  ALU zero flag, valid in EXEC.
REQ-007 mem_ready  input  1  memory handshake; access completes in a cycle where mem_read or mem_write=1 and mem_ready=1.
REQ-008 mem_read, mem_write  output  1 each  memory strobes.
REQ-009 ir_write, pc_write, reg_write  output  1 each  register load enables.
REQ-010 alu_src_b  output  2  ALU B select: 00 reg, 01 const 4, 10 immediate.
REQ-011 alu_op  output  2  00 add, 01 subtract, 10 funct-decoded.
REQ-012 mem_to_reg, pc_src, addr_src  output  1 each  mux selects: 1 means memory data, ALU result, ALU result respectively; 0 means ALU result, PC+4, PC.
REQ-013 halted, illegal  output  1 each  status flags.
REQ-014 state  output  3  current state encoding.
REQ-015 retired  output  CNT_W  count of completed instructions.

Function
REQ-016 States SHALL be encoded IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL transition to HALT with illegal=1.
REQ-017 IDLE: all strobes 0; next FETCH when go_contr=1, else stay.
REQ-018 FETCH: mem_read=1, addr_src=0; ir_write=1, pc_write=1, pc_src=0, alu_src_b=01 only when mem_ready=1; next DECODE on mem_ready=1, else stay in FETCH with no state changes.
REQ-019 DECODE: no strobes; next HALT if ir==32'hFFFFFFFF; else EXEC when ir[6:0] is 0110011, 0010011, 0000011, 0100011 or 1100011; else HALT with illegal set.
REQ-020 EXEC R-type (0110011): alu_src_b=00, alu_op=10; next WB.
REQ-021 EXEC I-type (0010011): alu_src_b=10, alu_op=10; next WB.
REQ-022 EXEC load/store: alu_src_b=10, alu_op=00; next MEM.
REQ-023 EXEC branch: alu_src_b=00, alu_op=01; pc_write=1, pc_src=1 when (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 never taken; next FETCH.
REQ-024 MEM: addr_src=1, mem_read=1 for load, mem_write=1 for store; wait while mem_ready=0; on mem_ready=1 load goes to WB, store goes to FETCH.
REQ-025 WB: reg_write=1; mem_to_reg=1 for load, 0 otherwise; next FETCH.
REQ-026 retired SHALL increment by 1 on the cycle leaving WB, leaving MEM for a store, or leaving EXEC for a branch; it wraps modulo 2^CNT_W.
REQ-027 Latency with mem_ready tied high: branch 3 cycles, R/I/store 4, load 5, each counted from FETCH entry to next FETCH entry.
REQ-028 HALT: sticky until reset; halted=1; all strobes 0; go_contr ignored.
REQ-029 illegal SHALL be set only by DECODE of an unsupported opcode or by state code 7, and held until reset.
REQ-030 go_contr deassertion outside IDLE SHALL have no effect.
REQ-031 mem_read and mem_write SHALL never both be 1.

Reset
REQ-032 On reset=1 at a rising edge: state=IDLE, retired=0, halted=0, illegal=0; all strobes and selects 0 in the next cycle, from any state including mid-wait on mem_ready.
REQ-033 reset SHALL take priority over go_contr and all transitions.

Verification
REQ-034 Reset, go_contr=1, mem_ready=1, ir=0x002081B3 (add) -> states 1,2,3,5,1; reg_write=1 in WB only; retired=1.
REQ-035 ir=0x0000A103 (lw), mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_read=1; WB with mem_to_reg=1; retired +1.
REQ-036 ir=0x00208463 (beq): zero=1 gives pc_write=1 and pc_src=1 in EXEC; zero=0 gives pc_write=0; both return to FETCH.
REQ-037 ir=0xFFFFFFFF in DECODE -> HALT, halted=1, illegal=0; go_contr pulse has no effect; reset returns to IDLE.
REQ-038 ir=0x0000007F -> HALT with illegal=1; reset asserted during a FETCH wait -> IDLE next cycle, retired=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle RISC-V style datapath. It sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and drives the
//   datapath strobes and mux selects. It also counts retired instructions.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   go_contr   : start request, honoured only in IDLE
//   ir[31:0]   : current instruction register
//   zero       : ALU zero flag, meaningful in EXEC
//   mem_ready  : memory handshake for FETCH and MEM accesses
//   mem_read / mem_write              : memory strobes
//   ir_write / pc_write / reg_write   : register load enables
//   alu_src_b[1:0] : 00 reg, 01 const 4, 10 immediate
//   alu_op[1:0]    : 00 add, 01 subtract, 10 funct-decoded
//   mem_to_reg / pc_src / addr_src    : datapath mux selects
//   halted / illegal                  : status flags
//   state[2:0]     : current state encoding
//   retired        : count of completed instructions (wraps)
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_contr,
  input  logic [31:0]      ir,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic             addr_src,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg, state_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire_pulse;

  // Instruction class decode; ir is held stable by the datapath after FETCH.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_load, is_store, is_branch, is_supported;
  logic       branch_taken;

  assign opcode       = ir[6:0];
  assign funct3       = ir[14:12];
  assign is_r         = (opcode == OP_R);
  assign is_i         = (opcode == OP_I);
  assign is_load      = (opcode == OP_LOAD);
  assign is_store     = (opcode == OP_STORE);
  assign is_branch    = (opcode == OP_BRANCH);
  assign is_supported = is_r | is_i | is_load | is_store | is_branch;
  // Only beq and bne are implemented; every other funct3 falls through.
  assign branch_taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

  // State register, sticky illegal flag and retired counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (retire_pulse) begin
        retired_reg <= retired_reg + CNT_ONE;
      end
    end
  end

  // Next-state logic; retire_pulse marks the final cycle of an instruction.
  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    retire_pulse = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (go_contr) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (ir == 32'hFFFF_FFFF) begin
          state_next = S_HALT;
        end else if (is_supported) begin
          state_next = S_EXEC;
        end else begin
          state_next   = S_HALT;
          illegal_next = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          state_next   = S_FETCH;
          retire_pulse = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            state_next = S_WB;
          end else begin
            state_next   = S_FETCH;
            retire_pulse = is_store;
          end
        end
      end
      S_WB: begin
        state_next   = S_FETCH;
        retire_pulse = 1'b1;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        // Unused encoding: park in HALT and flag it.
        state_next   = S_HALT;
        illegal_next = 1'b1;
      end
    endcase
  end

  // Output decode; FETCH and EXEC outputs also depend on live inputs.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    addr_src   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        // Latch IR and advance PC only in the cycle the read completes.
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
        end else if (is_i) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end else if (is_load || is_store) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b00;
        end else if (is_branch) begin
          alu_src_b = 2'b00;
          alu_op    = 2'b01;
          pc_write  = branch_taken;
          pc_src    = branch_taken;
        end
      end
      S_MEM: begin
        addr_src  = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
      end
      default: ;
    endcase
  end

  assign halted  = (state_reg == S_HALT);
  assign illegal = illegal_reg;
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scenario tasks push per-cycle stimulus together with the expected
//   state/output vector into a queue, then replay it cycle by cycle and
//   compare the DUT against each popped entry.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go_contr = 1'b0;
  logic [31:0]   ir = 32'h0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_read, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]    alu_src_b, alu_op;
  logic          mem_to_reg, pc_src, addr_src, halted, illegal;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .go_contr(go_contr), .ir(ir), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .addr_src(addr_src), .halted(halted), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // {state, mem_read, mem_write, ir_write, pc_write, reg_write,
  //  alu_src_b, alu_op, mem_to_reg, pc_src, addr_src, halted, illegal}
  logic [16:0] obs;
  assign obs = {state, mem_read, mem_write, ir_write, pc_write, reg_write,
                alu_src_b, alu_op, mem_to_reg, pc_src, addr_src, halted, illegal};

  localparam logic [16:0] X_IDLE  = {3'd0, 5'b00000, 2'b00, 2'b00, 5'b00000};
  localparam logic [16:0] X_FGO   = {3'd1, 5'b10110, 2'b01, 2'b00, 5'b00000};
  localparam logic [16:0] X_FWAIT = {3'd1, 5'b10000, 2'b00, 2'b00, 5'b00000};
  localparam logic [16:0] X_DEC   = {3'd2, 5'b00000, 2'b00, 2'b00, 5'b00000};
  localparam logic [16:0] X_ER    = {3'd3, 5'b00000, 2'b00, 2'b10, 5'b00000};
  localparam logic [16:0] X_EI    = {3'd3, 5'b00000, 2'b10, 2'b10, 5'b00000};
  localparam logic [16:0] X_ELS   = {3'd3, 5'b00000, 2'b10, 2'b00, 5'b00000};
  localparam logic [16:0] X_EBT   = {3'd3, 5'b00010, 2'b00, 2'b01, 5'b01000};
  localparam logic [16:0] X_EBN   = {3'd3, 5'b00000, 2'b00, 2'b01, 5'b00000};
  localparam logic [16:0] X_MLD   = {3'd4, 5'b10000, 2'b00, 2'b00, 5'b00100};
  localparam logic [16:0] X_MST   = {3'd4, 5'b01000, 2'b00, 2'b00, 5'b00100};
  localparam logic [16:0] X_WBR   = {3'd5, 5'b00001, 2'b00, 2'b00, 5'b00000};
  localparam logic [16:0] X_WBL   = {3'd5, 5'b00001, 2'b00, 2'b00, 5'b10000};
  localparam logic [16:0] X_HOK   = {3'd6, 5'b00000, 2'b00, 2'b00, 5'b00010};
  localparam logic [16:0] X_HIL   = {3'd6, 5'b00000, 2'b00, 2'b00, 5'b00011};

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_HLT  = 32'hFFFFFFFF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct packed {
    logic        go;
    logic        mrdy;
    logic        z;
    logic [31:0] instr;
    logic [16:0] exp;
  } ent_t;

  ent_t sb[$];

  task automatic push(input logic g, input logic m, input logic z,
                      input logic [31:0] i, input logic [16:0] x);
    ent_t e;
    e.go = g; e.mrdy = m; e.z = z; e.instr = i; e.exp = x;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    go_contr = 1'b0; mem_ready = 1'b0; zero = 1'b0; ir = 32'h0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (obs !== X_IDLE) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, X_IDLE);
    end
    total++;
    if (retired !== '0) begin
      bad++;
      $display("FAIL reset_retired: got %0d want 0", retired);
    end
    $display("test_reset: state=%0d retired=%0d", state, retired);
  endtask

  task automatic test_rtype();
    int n = 0;
    apply_reset();
    push(1, 1, 0, I_ADD, X_IDLE);
    push(0, 1, 0, I_ADD, X_FGO);
    push(0, 1, 0, I_ADD, X_DEC);
    push(0, 1, 0, I_ADD, X_ER);
    push(0, 1, 0, I_ADD, X_WBR);
    push(0, 1, 0, I_ADD, X_FGO);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL rtype step %0d: got %h want %h", n, obs, e.exp);
      end else $display("rtype step %0d: state=%0d ok", n, state);
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 4'd1) begin
      bad++;
      $display("FAIL rtype_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_load_wait();
    int n = 0;
    apply_reset();
    push(1, 0, 0, I_LW, X_IDLE);
    push(0, 0, 0, I_LW, X_FWAIT);
    push(0, 1, 0, I_LW, X_FGO);
    push(0, 1, 0, I_LW, X_DEC);
    push(0, 1, 0, I_LW, X_ELS);
    push(0, 0, 0, I_LW, X_MLD);
    push(0, 0, 0, I_LW, X_MLD);
    push(0, 0, 0, I_LW, X_MLD);
    push(0, 1, 0, I_LW, X_MLD);
    push(0, 1, 0, I_LW, X_WBL);
    push(0, 1, 0, I_LW, X_FGO);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL load step %0d: got %h want %h", n, obs, e.exp);
      end else $display("load step %0d: state=%0d ok", n, state);
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 4'd1) begin
      bad++;
      $display("FAIL load_retired: got %0d want 1", retired);
    end
  endtask

  task automatic test_branch();
    int n = 0;
    apply_reset();
    push(1, 1, 0, I_BEQ, X_IDLE);
    push(0, 1, 0, I_BEQ, X_FGO);
    push(0, 1, 0, I_BEQ, X_DEC);
    push(0, 1, 1, I_BEQ, X_EBT);   // beq, zero=1: taken
    push(0, 1, 0, I_BEQ, X_FGO);
    push(0, 1, 0, I_BEQ, X_DEC);
    push(0, 1, 0, I_BEQ, X_EBN);   // beq, zero=0: not taken
    push(0, 1, 0, I_BNE, X_FGO);
    push(0, 1, 0, I_BNE, X_DEC);
    push(0, 1, 0, I_BNE, X_EBT);   // bne, zero=0: taken
    push(0, 1, 1, I_BLT, X_FGO);
    push(0, 1, 1, I_BLT, X_DEC);
    push(0, 1, 1, I_BLT, X_EBN);   // other funct3: never taken
    push(0, 1, 0, I_BLT, X_FGO);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL branch step %0d: got %h want %h", n, obs, e.exp);
      end else $display("branch step %0d: state=%0d ok", n, state);
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 4'd4) begin
      bad++;
      $display("FAIL branch_retired: got %0d want 4", retired);
    end
  endtask

  // add, addi, sw (with one MEM wait), beq taken, then 13 untaken beq:
  // 17 retirements wrap the 4-bit counter to 1.
  task automatic test_back_to_back();
    int n = 0;
    apply_reset();
    push(1, 1, 0, I_ADD, X_IDLE);
    push(0, 1, 0, I_ADD, X_FGO);
    push(0, 1, 0, I_ADD, X_DEC);
    push(0, 1, 0, I_ADD, X_ER);
    push(0, 1, 0, I_ADD, X_WBR);
    push(0, 1, 0, I_ADDI, X_FGO);
    push(0, 1, 0, I_ADDI, X_DEC);
    push(0, 1, 0, I_ADDI, X_EI);
    push(0, 1, 0, I_ADDI, X_WBR);
    push(0, 1, 0, I_SW, X_FGO);
    push(0, 1, 0, I_SW, X_DEC);
    push(0, 1, 0, I_SW, X_ELS);
    push(0, 0, 0, I_SW, X_MST);
    push(0, 1, 0, I_SW, X_MST);
    push(0, 1, 1, I_BEQ, X_FGO);
    push(0, 1, 1, I_BEQ, X_DEC);
    push(0, 1, 1, I_BEQ, X_EBT);
    for (int k = 0; k < 13; k++) begin
      push(0, 1, 0, I_BEQ, X_FGO);
      push(0, 1, 0, I_BEQ, X_DEC);
      push(0, 1, 0, I_BEQ, X_EBN);
    end
    push(0, 1, 0, I_BEQ, X_FGO);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL b2b step %0d: got %h want %h", n, obs, e.exp);
      end else $display("b2b step %0d: state=%0d retired=%0d ok", n, state, retired);
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 4'd1) begin
      bad++;
      $display("FAIL b2b_retired_wrap: got %0d want 1", retired);
    end
  endtask

  task automatic test_halt();
    int n = 0;
    apply_reset();
    push(1, 1, 0, I_HLT, X_IDLE);
    push(0, 1, 0, I_HLT, X_FGO);
    push(0, 1, 0, I_HLT, X_DEC);
    push(1, 1, 0, I_HLT, X_HOK);   // go pulse ignored in HALT
    push(0, 1, 0, I_HLT, X_HOK);
    push(0, 1, 0, I_HLT, X_HOK);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL halt step %0d: got %h want %h", n, obs, e.exp);
      end else $display("halt step %0d: state=%0d ok", n, state);
      n++;
      @(posedge clk); #1;
    end
    apply_reset();
    total++;
    if (obs !== X_IDLE) begin
      bad++;
      $display("FAIL halt_reset: got %h want %h", obs, X_IDLE);
    end
  endtask

  task automatic test_illegal_and_fetch_reset();
    int n = 0;
    apply_reset();
    push(1, 1, 0, I_ADD, X_IDLE);
    push(0, 1, 0, I_ADD, X_FGO);
    push(0, 1, 0, I_ADD, X_DEC);
    push(0, 1, 0, I_ADD, X_ER);
    push(0, 1, 0, I_ADD, X_WBR);
    push(0, 1, 0, I_BAD, X_FGO);
    push(0, 1, 0, I_BAD, X_DEC);
    push(1, 1, 0, I_BAD, X_HIL);
    push(0, 1, 0, I_BAD, X_HIL);
    while (sb.size() > 0) begin
      ent_t e;
      e = sb.pop_front();
      go_contr = e.go; mem_ready = e.mrdy; zero = e.z; ir = e.instr;
      #1;
      total++;
      if (obs !== e.exp) begin
        bad++;
        $display("FAIL illegal step %0d: got %h want %h", n, obs, e.exp);
      end else $display("illegal step %0d: state=%0d ok", n, state);
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (retired !== 4'd1) begin
      bad++;
      $display("FAIL illegal_retired: got %0d want 1", retired);
    end
    // Leave HALT, start again and reset while FETCH waits on memory.
    apply_reset();
    go_contr = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    go_contr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== X_FWAIT) begin
      bad++;
      $display("FAIL fetch_wait: got %h want %h", obs, X_FWAIT);
    end
    reset = 1'b1; go_contr = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; go_contr = 1'b0;
    total++;
    if (obs !== X_IDLE) begin
      bad++;
      $display("FAIL fetch_wait_reset: got %h want %h", obs, X_IDLE);
    end
    total++;
    if (retired !== '0) begin
      bad++;
      $display("FAIL fetch_wait_reset_retired: got %0d want 0", retired);
    end
    $display("fetch-wait reset: state=%0d retired=%0d", state, retired);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_halt();
    test_illegal_and_fetch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
